// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT control and the IF/ID pipeline register.
// Defining FETCH_CNT_EN adds a counter of valid IF/ID loads on FetchCnt; otherwise FetchCnt is tied to 0.
module instr_fetch #(
   parameter int BITS_DATA = 32,
   parameter int BITS_ADDR = 5,
   parameter int LAST_ADDR = 23
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 StallF,
   input  logic                 StallD,
   input  logic                 FlushD,
   input  logic                 PCSrcE,
   input  logic [31:0]          PCTargetE,
   output logic [BITS_ADDR-1:0] AddrF,
   input  logic [BITS_DATA-1:0] InstrF,
   output logic [31:0]          PCF,
   output logic [31:0]          PCD,
   output logic [31:0]          PCPlus4D,
   output logic [BITS_DATA-1:0] InstrD,
   output logic                 ValidD,
   output logic                 HaltF,
   output logic [31:0]          FetchCnt,
   output logic [1:0]           o_dbg_state
);

   localparam logic [1:0]  S_BOOT    = 2'd0;
   localparam logic [1:0]  S_RUN     = 2'd1;
   localparam logic [1:0]  S_HALT    = 2'd2;
   localparam logic [31:0] LAST_WORD = 32'(LAST_ADDR);

   logic [1:0]           r_state;
   logic [31:0]          r_pc;
   logic [BITS_DATA-1:0] r_instr_d;
   logic [31:0]          r_pc_d;
   logic [31:0]          r_pc4_d;
   logic                 r_valid_d;

   logic [31:0] w_target;
   logic [31:0] w_pc_plus4;
   logic        w_tgt_beyond;
   logic        w_at_last;
   logic        w_capture;
   logic [31:0] w_next_pc;
   logic [1:0]  w_next_state;

   assign w_target     = PCTargetE & ~32'd3;
   assign w_pc_plus4   = r_pc + 32'd4;
   assign w_tgt_beyond = (w_target >> 2) > LAST_WORD;
   assign w_at_last    = (r_pc >> 2) >= LAST_WORD;
   assign w_capture    = (r_state == S_RUN) && !FlushD && !StallD;

   // Redirect beats stall beats sequential advance; a redirect past the image halts fetch.
   always_comb begin
      w_next_pc    = r_pc;
      w_next_state = r_state;
      case (r_state)
         S_BOOT: w_next_state = S_RUN;
         S_RUN: begin
            if (PCSrcE) begin
               w_next_pc    = w_target;
               w_next_state = w_tgt_beyond ? S_HALT : S_RUN;
            end else if (!StallF) begin
               if (w_at_last) begin
                  w_next_state = S_HALT;
               end else begin
                  w_next_pc = w_pc_plus4;
               end
            end
         end
         S_HALT: begin
            if (PCSrcE) begin
               w_next_pc    = w_target;
               w_next_state = w_tgt_beyond ? S_HALT : S_RUN;
            end
         end
         default: w_next_state = S_BOOT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_BOOT;
         r_pc    <= '0;
      end else begin
         r_state <= w_next_state;
         r_pc    <= w_next_pc;
      end
   end

   // Flush wins over stall; outside RUN the register fills with bubbles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_instr_d <= '0;
         r_pc_d    <= '0;
         r_pc4_d   <= '0;
         r_valid_d <= 1'b0;
      end else if (FlushD || (!StallD && !w_capture)) begin
         r_instr_d <= '0;
         r_pc_d    <= '0;
         r_pc4_d   <= '0;
         r_valid_d <= 1'b0;
      end else if (w_capture) begin
         r_instr_d <= InstrF;
         r_pc_d    <= r_pc;
         r_pc4_d   <= w_pc_plus4;
         r_valid_d <= 1'b1;
      end
   end

`ifdef FETCH_CNT_EN
   logic [31:0] r_fetch_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fetch_cnt <= '0;
      end else if (w_capture) begin
         r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
   end

   assign FetchCnt = r_fetch_cnt;
`else
   assign FetchCnt = '0;
`endif

   assign AddrF       = r_pc[BITS_ADDR+1:2];
   assign PCF         = r_pc;
   assign PCD         = r_pc_d;
   assign PCPlus4D    = r_pc4_d;
   assign InstrD      = r_instr_d;
   assign ValidD      = r_valid_d;
   assign HaltF       = (r_state == S_HALT);
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a cycle model built from the fetch rules, checked every cycle,
// plus directed scenarios with literal expectations.
module tb_instr_fetch;

   localparam int LAST = 23;

   logic        clk = 1'b0;
   logic        reset;
   logic        StallF, StallD, FlushD, PCSrcE;
   logic [31:0] PCTargetE;
   logic [4:0]  AddrF;
   logic [31:0] InstrF;
   logic [31:0] PCF, PCD, PCPlus4D, InstrD, FetchCnt;
   logic        ValidD, HaltF;
   logic [1:0]  o_dbg_state;

   logic [31:0] rom [0:31];

   always #5 clk = ~clk;

   assign InstrF = rom[AddrF];

   instr_fetch #(.BITS_DATA(32), .BITS_ADDR(5), .LAST_ADDR(LAST)) dut (
      .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
      .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .AddrF(AddrF), .InstrF(InstrF),
      .PCF(PCF), .PCD(PCD), .PCPlus4D(PCPlus4D), .InstrD(InstrD), .ValidD(ValidD),
      .HaltF(HaltF), .FetchCnt(FetchCnt), .o_dbg_state(o_dbg_state)
   );

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: fetch PC, boot/halt flags and the decode-side view.
   logic [31:0] m_pc, m_instr, m_pcd, m_pc4d, m_cnt;
   logic        m_valid, m_boot, m_halt, m_cap;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_pc = 0; m_instr = 0; m_pcd = 0; m_pc4d = 0; m_cnt = 0;
         m_valid = 0; m_boot = 1; m_halt = 0;
      end else begin
         m_cap = !m_boot && !m_halt && !FlushD && !StallD;
         if (FlushD || (!StallD && !m_cap)) begin
            m_instr = 0; m_pcd = 0; m_pc4d = 0; m_valid = 0;
         end else if (m_cap) begin
            m_instr = rom[(m_pc / 4) % 32]; m_pcd = m_pc; m_pc4d = m_pc + 4; m_valid = 1;
         end
`ifdef FETCH_CNT_EN
         if (m_cap) m_cnt = m_cnt + 1;
`endif
         if (m_boot) begin
            m_boot = 0;
         end else if (PCSrcE) begin
            m_pc   = {PCTargetE[31:2], 2'b00};
            m_halt = (m_pc / 4) > LAST;
         end else if (!m_halt && !StallF) begin
            if ((m_pc / 4) >= LAST) m_halt = 1;
            else m_pc = m_pc + 4;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_PCF", PCF, m_pc);
         chk("cyc_AddrF", {27'd0, AddrF}, (m_pc / 4) % 32);
         chk("cyc_InstrD", InstrD, m_instr);
         chk("cyc_PCD", PCD, m_pcd);
         chk("cyc_PCPlus4D", PCPlus4D, m_pc4d);
         chk("cyc_ValidD", {31'd0, ValidD}, {31'd0, m_valid});
         chk("cyc_HaltF", {31'd0, HaltF}, {31'd0, m_halt});
         chk("cyc_FetchCnt", FetchCnt, m_cnt);
         chk("cyc_state", {30'd0, o_dbg_state}, m_boot ? 32'd0 : (m_halt ? 32'd2 : 32'd1));
      end
   end

   task automatic tick(input logic stf, input logic std, input logic fld, input logic src,
                       input logic [31:0] tgt);
      StallF = stf; StallD = std; FlushD = fld; PCSrcE = src; PCTargetE = tgt;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      tick(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
   endtask

   task automatic async_reset(input string tag);
      @(posedge clk);
      #2;
      reset = 1'b1;
      StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 0;
      #1;
      chk({tag, "_rst_PCF"}, PCF, 32'd0);
      chk({tag, "_rst_AddrF"}, {27'd0, AddrF}, 32'd0);
      chk({tag, "_rst_PCD"}, PCD, 32'd0);
      chk({tag, "_rst_PCPlus4D"}, PCPlus4D, 32'd0);
      chk({tag, "_rst_InstrD"}, InstrD, 32'd0);
      chk({tag, "_rst_ValidD"}, {31'd0, ValidD}, 32'd0);
      chk({tag, "_rst_HaltF"}, {31'd0, HaltF}, 32'd0);
      chk({tag, "_rst_FetchCnt"}, FetchCnt, 32'd0);
      chk({tag, "_rst_state"}, {30'd0, o_dbg_state}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk({tag, "_boot_PCF"}, PCF, 32'd0);
      chk({tag, "_boot_state"}, {30'd0, o_dbg_state}, 32'd0);
   endtask

   initial begin
      for (int k = 0; k < 32; k++) rom[k] = k;
      reset = 1'b1;
      StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      chk("reset_PCF", PCF, 32'd0);
      chk("reset_ValidD", {31'd0, ValidD}, 32'd0);
      reset = 1'b0;
      #1;
      chk("boot_state", {30'd0, o_dbg_state}, 32'd0);
      chk("boot_PCF", PCF, 32'd0);

      idle();
      chk("run0_PCF", PCF, 32'd0);
      chk("run0_ValidD", {31'd0, ValidD}, 32'd0);
      idle();
      chk("run1_PCF", PCF, 32'h4);
      chk("run1_InstrD", InstrD, 32'd0);
      chk("run1_ValidD", {31'd0, ValidD}, 32'd1);
      chk("run1_PCPlus4D", PCPlus4D, 32'h4);
      idle();
      chk("run2_PCF", PCF, 32'h8);
      chk("run2_InstrD", InstrD, 32'd1);

      repeat (3) begin
         tick(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
         chk("stall_PCF", PCF, 32'h8);
         chk("stall_InstrD", InstrD, 32'd1);
         chk("stall_PCD", PCD, 32'h4);
      end
      idle();
      chk("resume_PCF", PCF, 32'hC);
      chk("resume_InstrD", InstrD, 32'd2);

      tick(1'b0, 1'b0, 1'b1, 1'b1, 32'h15);
      chk("redir_PCF", PCF, 32'h14);
      chk("redir_ValidD", {31'd0, ValidD}, 32'd0);
      idle();
      chk("redir_InstrD", InstrD, 32'd5);
      chk("redir_PCD", PCD, 32'h14);

      tick(1'b0, 1'b0, 1'b1, 1'b1, 32'h5C);
      chk("last_PCF", PCF, 32'h5C);
      idle();
      chk("halt_HaltF", {31'd0, HaltF}, 32'd1);
      chk("halt_PCF", PCF, 32'h5C);
      chk("halt_InstrD", InstrD, 32'd23);
      idle();
      chk("halt2_PCF", PCF, 32'h5C);
      chk("halt2_ValidD", {31'd0, ValidD}, 32'd0);
      tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      chk("restart_HaltF", {31'd0, HaltF}, 32'd0);
      chk("restart_PCF", PCF, 32'h0);
      idle();
      chk("restart_ValidD", {31'd0, ValidD}, 32'd1);

      tick(1'b1, 1'b0, 1'b1, 1'b1, 32'h40);
      chk("redir_stall_PCF", PCF, 32'h40);
      idle();
      chk("redir_stall_InstrD", InstrD, 32'd16);

      tick(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
      chk("far_PCF", PCF, 32'hFFFF_FFFC);
      chk("far_AddrF", {27'd0, AddrF}, 32'd31);
      chk("far_HaltF", {31'd0, HaltF}, 32'd1);
      tick(1'b0, 1'b0, 1'b1, 1'b1, 32'h8);
      chk("far_back_PCF", PCF, 32'h8);
      idle();
      tick(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      chk("stalld_PCF", PCF, 32'h10);
      chk("stalld_InstrD", InstrD, 32'd2);
      idle();
      chk("stalld_after_InstrD", InstrD, 32'd4);

      for (int i = 0; i < 60; i++) begin
         logic src;
         src = ($urandom_range(0, 5) == 0);
         tick($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              src || ($urandom_range(0, 7) == 0), src,
              $urandom_range(0, 27) * 4 + $urandom_range(0, 3));
      end

      tick(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
      tick(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
      async_reset("stall");

      idle();
      for (int i = 0; i < 12; i++) begin
         tick(1'b0, 1'b0, (i == 3) || (i == 7), 1'b0, 32'd0);
      end
`ifdef FETCH_CNT_EN
      chk("count_FetchCnt", FetchCnt, 32'd10);
`else
      chk("count_FetchCnt", FetchCnt, 32'd0);
`endif

      tick(1'b0, 1'b0, 1'b1, 1'b1, 32'h7C);
      chk("beyond_HaltF", {31'd0, HaltF}, 32'd1);
      async_reset("halt");
      idle();
      idle();
      chk("final_PCF", PCF, 32'h4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter BITS_DATA, default 32, instruction width, matching the instruction ROM data width.
REQ-002 The block SHALL have parameter BITS_ADDR, default 5, ROM word-address width.
REQ-003 The block SHALL have parameter LAST_ADDR, default 23, highest loaded ROM word index.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-006 The block SHALL have port StallF, input, 1 bit; while high, the PC holds.
REQ-007 The block SHALL have port StallD, input, 1 bit; while high, the IF/ID register holds.
REQ-008 The block SHALL have port FlushD, input, 1 bit; when high, IF/ID is cleared to a bubble.
REQ-009 The block SHALL have port PCSrcE, input, 1 bit; when high, the PC is redirected to PCTargetE.
REQ-010 The block SHALL have port PCTargetE, input, 32 bits, the byte-address redirect target.
REQ-011 The block SHALL have port AddrF, output, BITS_ADDR bits, ROM word address, equal to PCF[BITS_ADDR+1:2].
REQ-012 The block SHALL have port InstrF, input, BITS_DATA bits, combinational ROM read data for AddrF.
REQ-013 The block SHALL have ports PCF, PCD and PCPlus4D, outputs, 32 bits each: the fetch PC, the decode PC and the decode PC+4.
REQ-014 The block SHALL have ports InstrD, output, BITS_DATA bits, and ValidD, output, 1 bit; ValidD=1 means InstrD is real.
REQ-015 The block SHALL have port HaltF, output, 1 bit; high means fetch has ended.
REQ-016 The block SHALL have port FetchCnt, output, 32 bits, the count of instructions fetched.

Function
REQ-017 The PC SHALL be a 32-bit byte-address register; PCF[1:0] SHALL always be 0.
REQ-018 The FSM SHALL have states BOOT, RUN and HALT; reset SHALL enter BOOT.
REQ-019 In BOOT, the block SHALL hold PCF=0 and ValidD=0 for exactly one cycle, then move to RUN.
REQ-020 The next-PC priority SHALL be: PCSrcE (load {PCTargetE[31:2],2'b00}, even while StallF is high) > StallF (hold) > PCF+4.
REQ-021 In RUN, when neither StallD nor FlushD is high, IF/ID SHALL capture InstrF, PCF and PCF+4 with ValidD=1; latency from PCF to InstrD SHALL be one cycle.
REQ-022 FlushD SHALL override StallD and SHALL force InstrD=0, PCD=0, PCPlus4D=0 and ValidD=0.
REQ-023 PCSrcE=1 SHALL NOT by itself clear IF/ID; the hazard unit supplies FlushD.
REQ-024 The PC SHALL wrap modulo 2^32; AddrF SHALL wrap modulo 2^BITS_ADDR.
REQ-025 RUN SHALL go to HALT when the PC would advance sequentially past word LAST_ADDR; in HALT, HaltF=1, the PC holds and IF/ID captures bubbles (ValidD=0).
REQ-026 PCSrcE=1 in HALT SHALL load the target and return to RUN; HaltF SHALL clear on the same edge.
REQ-027 A PCSrcE target with word index above LAST_ADDR SHALL enter HALT on the next cycle.

Reset
REQ-028 Reset SHALL act immediately, without waiting for clk.
REQ-029 Reset values SHALL be: PCF=0, AddrF=0, PCD=0, PCPlus4D=0, InstrD=0, ValidD=0, HaltF=0, FetchCnt=0, state BOOT.
REQ-030 Reset asserted mid-stall, mid-flush or in HALT SHALL produce the same values as REQ-029; release SHALL restart at BOOT.

Configuration
REQ-031 With macro FETCH_CNT_EN defined, FetchCnt SHALL increment by 1 (wrapping at 2^32) on every edge that loads IF/ID with ValidD=1.
REQ-032 Without FETCH_CNT_EN, FetchCnt SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-033 Scenario: release reset, no stalls, ROM word k = k -> AddrF 0,1,2,… from cycle 1; InstrD=k one cycle after AddrF=k; ValidD=0 during the BOOT cycle.
REQ-034 Scenario: StallF=StallD=1 for 3 cycles at PCF=0x8 -> PCF stays 0x8 and InstrD/PCD stay frozen; sequence resumes at 0xC.
REQ-035 Scenario: PCSrcE=1, PCTargetE=0x15, FlushD=1 -> next PCF=0x14, ValidD=0, then InstrD = ROM word 5.
REQ-036 Scenario: run to PCF=0x5C (word 23) -> HaltF=1 next cycle, PCF holds, ValidD=0 thereafter; a PCSrcE to 0x0 restarts fetch.
REQ-037 Scenario: assert reset asynchronously mid-cycle during a stall -> all outputs reach REQ-029 values before the next clk edge.
REQ-038 Scenario: with FETCH_CNT_EN, 10 valid fetches plus 2 flushes -> FetchCnt=10; without FETCH_CNT_EN -> FetchCnt=0.
